// File: rtl/imem_dmem_port_arb_pkg.sv
// ---------------------------------------------------------------------------
// imem_dmem_port_arb_pkg
// Shared definitions for the fetch/data SRAM port arbiter: default bus widths,
// streak counter width and the response tag encoding.
// ---------------------------------------------------------------------------
package imem_dmem_port_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned STREAK_W   = 4;

    // Owner of the read data returning from the SRAM in the current cycle.
    typedef enum logic [1:0] {
        RTAG_NONE = 2'd0,
        RTAG_IF   = 2'd1,
        RTAG_DM   = 2'd2
    } rtag_e;

endpackage

// File: rtl/imem_dmem_port_arb.sv
// ---------------------------------------------------------------------------
// imem_dmem_port_arb
// Shares one single-port, 1-cycle-latency SRAM between instruction fetch and
// the data-memory stage. Data has priority, except that fetch is forced
// through once data has won MAX_STREAK consecutive cycles while fetch waited.
// Read data is steered back by a registered response tag.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   if_req/if_addr        fetch read request
//   if_flush              branch redirect: kills fetch grant and fetch response
//   if_gnt                fetch request accepted this cycle
//   if_rvalid/if_rdata    fetch response (1 cycle after grant)
//   dm_req/dm_we/dm_addr/dm_wdata  data request (dm_we == 0 means load)
//   dm_gnt                data request accepted this cycle
//   dm_rvalid/dm_rdata    load response (1 cycle after grant)
//   sram_en/we/addr/wdata SRAM request side
//   sram_rdata            SRAM read data
//   if_stall_req          fetch waiting without flush
// ---------------------------------------------------------------------------
module imem_dmem_port_arb
    import imem_dmem_port_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic [DATA_W/8-1:0]   dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  sram_en,
    output logic [DATA_W/8-1:0]   sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  if_stall_req
);

    localparam logic [STREAK_W-1:0] C_MAX_STREAK = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    rtag_e               r_rtag;
    rtag_e               w_rtag_nxt;

    logic w_fetch_ok;
    logic w_force_if;
    logic w_dm_gnt;
    logic w_if_gnt;

    // Gating with rst_n keeps every grant (and thus sram_en) low during reset.
    assign w_fetch_ok = rst_n & if_req & ~if_flush;
    assign w_force_if = w_fetch_ok & (r_streak == C_MAX_STREAK);
    assign w_dm_gnt   = rst_n & dm_req & ~w_force_if;
    assign w_if_gnt   = w_fetch_ok & ~w_dm_gnt;

    assign dm_gnt       = w_dm_gnt;
    assign if_gnt       = w_if_gnt;
    assign if_stall_req = rst_n & if_req & ~w_if_gnt & ~if_flush;

    // Responses: a read outstanding when reset arrives is dropped, and a
    // flush in the response cycle kills the fetch response.
    assign if_rvalid = rst_n & (r_rtag == RTAG_IF) & ~if_flush;
    assign dm_rvalid = rst_n & (r_rtag == RTAG_DM);
    assign if_rdata  = sram_rdata;
    assign dm_rdata  = sram_rdata;

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_dm_gnt) begin
            sram_en    = 1'b1;
            sram_we    = dm_we;
            sram_addr  = dm_addr;
            sram_wdata = dm_wdata;
        end else if (w_if_gnt) begin
            sram_en   = 1'b1;
            sram_addr = if_addr;
        end
    end

    always_comb begin
        w_rtag_nxt = RTAG_NONE;
        if (w_dm_gnt && (dm_we == '0)) begin
            w_rtag_nxt = RTAG_DM;
        end else if (w_if_gnt) begin
            w_rtag_nxt = RTAG_IF;
        end
    end

    // Counts data wins while fetch is waiting; saturates at MAX_STREAK.
    always_comb begin
        w_streak_nxt = r_streak;
        if (!w_fetch_ok || w_if_gnt) begin
            w_streak_nxt = '0;
        end else if (w_dm_gnt && (r_streak != C_MAX_STREAK)) begin
            w_streak_nxt = r_streak + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rtag   <= RTAG_NONE;
            r_streak <= '0;
        end else begin
            r_rtag   <= w_rtag_nxt;
            r_streak <= w_streak_nxt;
        end
    end

endmodule

// File: doc/imem_dmem_port_arb.md
Name: imem_dmem_port_arb

Overview:
Arbiter that shares one single-port, 1-cycle-latency SRAM between the fetch stage (IF1 request / IF2 response) and the data-memory stage (MEM load/store).
- Grants at most one requester per cycle.
- Routes the next-cycle read data back to the owner via a registered response tag.
- Produces a fetch-stall request for the pipeline stall controller.
- Sits between the pipeline and the memory wrapper, replacing the direct inst/data SRAM connections.

Parameters:
- ADDR_W, 32, address width for both requesters and SRAM.
- DATA_W, 32, data width.
- MAX_STREAK, 4, max consecutive data grants while fetch waits before fetch is forced through (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch redirect (br_e); kills fetch grant and in-flight fetch response
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid this cycle
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  DATA_W/8  byte write enables (0 = read)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid this cycle
- dm_rdata  out  DATA_W  load data
- sram_en  out  1  SRAM enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after an enabled read
- if_stall_req  out  1  = if_req & !if_gnt & !if_flush

Behaviour:
- Grant is combinational on current-cycle inputs.
- Priority: data over fetch. Exception: fetch wins when if_req and streak_cnt == MAX_STREAK.
- fetch_ok = if_req & !if_flush.
- dm_gnt = dm_req & !(fetch_ok & streak_cnt == MAX_STREAK).
- if_gnt = fetch_ok & !dm_gnt.
- SRAM mux:
  - If dm_gnt: sram_en=1, sram_we=dm_we, sram_addr=dm_addr, sram_wdata=dm_wdata.
  - Else if if_gnt: sram_en=1, sram_we=0, sram_addr=if_addr, sram_wdata=0.
  - Else: sram_en=0, all other SRAM outputs 0.
- Response tag register `rtag`, encodings NONE/IF/DM. Next value at clock edge:
  - DM if dm_gnt & dm_we==0.
  - IF if if_gnt.
  - NONE otherwise, including data writes.
- Response outputs:
  - if_rvalid = (rtag==IF) & !if_flush. A flush in the response cycle kills that response.
  - dm_rvalid = (rtag==DM).
  - if_rdata = dm_rdata = sram_rdata, unconditionally. Each requester qualifies with its own rvalid.
  - Read latency is exactly 1 cycle after grant. Requesters must capture data in the rvalid cycle; the arbiter holds nothing.
- Streak counter `streak_cnt`, width 4:
  - Increments (saturating at MAX_STREAK) when dm_gnt & fetch_ok.
  - Clears to 0 on if_gnt or when !fetch_ok.
  - Holds otherwise.
- Simultaneous events:
  - if_flush with if_req: no fetch grant, no stall request; dm_req is served normally.
  - if_flush in the cycle after an IF grant: suppresses that if_rvalid.
  - Both requests with the counter saturated: fetch is granted, dm_gnt=0, counter clears.
- Reset (rst_n=0 at a clock edge): rtag=NONE, streak_cnt=0.
  - While rst_n is low, all gnt outputs, sram_en and if_stall_req are forced to 0.
  - The first cycle after reset has if_rvalid = dm_rvalid = 0.
  - A read outstanding when reset is asserted is discarded.
- No combinational path from sram_rdata to any grant.

Decomposition:
- Shared package (define.vh): RTAG_NONE=2'd0, RTAG_IF=2'd1, RTAG_DM=2'd2; ADDR_W/DATA_W defaults.
- No sub-module needed; counter and tag live in the single module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, dm_req=0 -> if_gnt=1, sram_addr=0x100, sram_we=0; next cycle if_rvalid=1, if_rdata=sram_rdata.
- Contention with MAX_STREAK=4: if_req and dm_req held high for 6 cycles, dm_we=0 ->
  - dm_gnt cycles 0-3; if_gnt cycle 4; dm_gnt cycle 5.
  - if_stall_req=1 in cycles 0-3 and 5.
  - dm_rvalid follows each data grant by 1 cycle.
- Store: dm_req=1, dm_we=4'b0011, dm_addr=0x2004, dm_wdata=0xDEADBEEF -> sram_we=0011, sram_wdata=0xDEADBEEF; next cycle dm_rvalid=0, if_rvalid=0.
- Flush kill: if_gnt in cycle N, if_flush=1 in cycle N+1 -> if_rvalid=0 in N+1. if_flush with if_req -> if_gnt=0, if_stall_req=0.
- Reset mid-operation: dm load granted, rst_n=0 next edge -> following cycle dm_rvalid=0, sram_en=0, streak_cnt back to 0. After release, the contention sequence restarts from cycle 0.
